csr_hpm_counters: RTL and testbench
===================================

# csr_hpm_counters

Parametrised machine-mode performance-counter bank for the RV32 pipeline's CSR unit: mcycle, minstret and NUM_COUNTERS programmable mhpmcounters, each 64-bit with 32-bit low/high CSR halves. Each mhpmcounter counts one event selected from a pipeline event vector. The block also implements mcountinhibit, mcounteren-gated user shadows and an optional overflow interrupt. It sits beside the core CSR register file and shares its read/write port timing.

## Interface
- DATA_WIDTH, 32, CSR data width; only 32 is supported.
- NUM_COUNTERS, 4, number of mhpmcounters, numbered 3..3+NUM_COUNTERS-1; legal range 1..29.
- NUM_EVENTS, 8, width of event_vec; legal range 1..255.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- priv_level  in  2  privilege of the accessing instruction.
- csr_raddr  in  12  read address.
- csr_rdata  out  DATA_WIDTH  read data, combinational.
- csr_hit  out  1  csr_raddr decodes to a register in this block.
- csr_illegal  out  1  the read is a user-shadow access blocked by mcounteren.
- csr_wen  in  1  write strobe.
- csr_waddr  in  12  write address.
- csr_wdata  in  DATA_WIDTH  write data.
- inst_commit  in  1  one instruction retired this cycle.
- event_vec  in  NUM_EVENTS  per-cycle event pulses.
- ovf_irq  out  1  registered overflow interrupt request.

## Operation
- Address map:
  - mcycle: 0xB00 / 0xB80.
  - minstret: 0xB02 / 0xB82.
  - mhpmcounter(3+i): 0xB03+i / 0xB83+i.
  - mhpmevent(3+i): 0x323+i.
  - mcountinhibit: 0x320.
  - mcounteren: 0x306.
  - ovf_status: 0x7C0.
  - User shadows: 0xC00+n / 0xC80+n.
- mcountinhibit bit n stops counter n. Bit 1 is hardwired to 0. Bits above 2+NUM_COUNTERS read 0.
- Increment rules:
  - mcycle increments +1 every cycle unless inhibited.
  - minstret increments when inst_commit=1, unless inhibited.
  - mhpmcounter(3+i) increments when sel=mhpmevent[7:0], 1<=sel<=NUM_EVENTS, and event_vec[sel-1]=1, unless inhibited. sel=0 or sel>NUM_EVENTS never counts.
- mhpmevent stores bits [7:0] and bit 31 (overflow IRQ enable); all other bits read 0.
- Counters are 64-bit and wrap modulo 2^64.
- Writes:
  - A write is accepted only if priv_level >= csr_waddr[9:8] and csr_waddr[11:10] != 2'b11.
  - Writes to shadows, unmapped addresses or unprivileged writes are silently dropped.
  - A write to one half of a counter replaces that half, keeps the other half, and suppresses that counter's increment in that cycle.
- Read bypass: if csr_wen=1 and csr_waddr==csr_raddr, csr_rdata=csr_wdata.
- Shadow reads:
  - Allowed when priv_level==2'b11, or when mcounteren[n]=1.
  - Otherwise csr_rdata=0 and csr_illegal=1.
- Unmapped csr_raddr: csr_rdata=0, csr_hit=0, csr_illegal=0.

## Timing
- Reads are zero-latency (combinational).
- Counter and CSR updates are visible on the read port the cycle after the clock edge.
- On rst, all of the following reset to 0, and ovf_irq=0 in the next cycle:
  - all counters;
  - mhpmevent, mcountinhibit, mcounteren;
  - ovf_status.
- rst asserted mid-count has priority over writes and increments in the same cycle.
- Simultaneous write and event on different counters: both take effect.
- Write to mcountinhibit in cycle t affects counting from cycle t+1; an increment in cycle t still uses the old inhibit value.

## Configuration
- HPM_OVF_IRQ_EN defined:
  - A mhpmcounter wrap from all-ones to 0 by increment sets sticky ovf_status[3+i]. A write-caused wrap does not set it.
  - ovf_status is write-1-to-clear at 0x7C0.
  - ovf_irq is registered: ovf_irq <= |(ovf_status_next & enable). enable[3+i] = mhpmevent(3+i)[31].
  - ovf_irq rises the cycle after the wrapping edge.
- HPM_OVF_IRQ_EN undefined:
  - ovf_irq is tied to 0.
  - 0x7C0 reads 0 with csr_hit=0, and writes to it are ignored.

## Test plan
- Reset, then run 10 cycles idle -> mcycle reads 10, minstret reads 0, every other register reads 0.
- Write mhpmevent3=2, pulse event_vec[1] on 5 cycles, set mcountinhibit bit3, pulse 3 more -> mhpmcounter3=5.
- Write 0xFFFFFFFF to 0xB03 and 0x0 to 0xB83, then one event -> 0xB03=0, 0xB83=1. Also: a write and an event on the same cycle -> the written value is kept with no increment.
- User read of 0xC00 with mcounteren=0 -> rdata=0, csr_illegal=1. With mcounteren=1 -> rdata=mcycle[31:0], csr_illegal=0.
- HPM_OVF_IRQ_EN: set mhpmevent3=0x80000001 and mhpmcounter3=2^64-1, then one event -> ovf_irq=1 next cycle. Write 0x8 to 0x7C0 -> ovf_irq=0 next cycle.
- User-mode write of 0xB00 -> ignored. csr_wen to 0x341 with csr_raddr=0x341 -> csr_hit=0, rdata=0 (bypass applies only to mapped addresses).

Source files
------------

// File: rtl/csr_hpm_counters.sv
// ----------------------------------------------------------------------------
// csr_hpm_counters
//
// Machine-mode performance counter bank for the RV32 CSR unit. Holds mcycle,
// minstret and NUM_COUNTERS programmable mhpmcounters (each 64 bits, accessed
// as 32-bit low/high halves), the mhpmevent selectors, mcountinhibit,
// mcounteren and the user-mode read-only shadows.
//
// Optional feature macro: HPM_OVF_IRQ_EN
//   defined   -> sticky overflow status at 0x7C0 (write-1-to-clear) plus a
//                registered overflow interrupt request on ovf_irq_o.
//   undefined -> ovf_irq_o is tied low and 0x7C0 is unmapped.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   priv_level_i   privilege of the accessing instruction
//   csr_raddr_i    read address
//   csr_rdata_o    read data (combinational)
//   csr_hit_o      read address maps to a register in this block
//   csr_illegal_o  user shadow read blocked by mcounteren
//   csr_wen_i      write strobe
//   csr_waddr_i    write address
//   csr_wdata_i    write data
//   inst_commit_i  one instruction retired this cycle
//   event_vec_i    per-cycle event pulses
//   ovf_irq_o      registered overflow interrupt request
// ----------------------------------------------------------------------------
module csr_hpm_counters #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_EVENTS   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            priv_level_i,
  input  logic [11:0]           csr_raddr_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  output logic                  csr_hit_o,
  output logic                  csr_illegal_o,
  input  logic                  csr_wen_i,
  input  logic [11:0]           csr_waddr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  input  logic                  inst_commit_i,
  input  logic [NUM_EVENTS-1:0] event_vec_i,
  output logic                  ovf_irq_o
);

  // Counter index n follows the CSR numbering: 0 = mcycle, 1 = time (not
  // implemented, kept at zero), 2 = minstret, 3.. = mhpmcounters.
  localparam int          TOP       = 2 + NUM_COUNTERS;
  localparam logic [32:0] LOW_ONES  = (33'h1 << (TOP + 1)) - 33'h1;
  localparam logic [31:0] IMPL_MASK = LOW_ONES[31:0] & ~32'h2;
  localparam logic [31:0] EVT_MASK  = 32'h8000_00FF;

  logic [63:0]  cnt_q [0:TOP];
  logic [63:0]  cnt_d [0:TOP];
  logic [31:0]  evt_q [0:NUM_COUNTERS-1];
  logic [31:0]  evt_d [0:NUM_COUNTERS-1];
  logic [31:0]  inhibit_q, inhibit_d;
  logic [31:0]  counteren_q, counteren_d;
  logic [255:0] evPad;
  logic [TOP:0] incReq;
  logic         wAcc;

`ifdef HPM_OVF_IRQ_EN
  logic [31:0] ovf_q, ovf_d;
  logic [31:0] ovfSet, ovfClr, ovfEn;
  logic        irq_q, irq_d;
`endif

  // Event vector shifted up by one so that selector value sel indexes
  // event_vec[sel-1] directly; sel = 0 and sel > NUM_EVENTS land on zeros.
  assign evPad = {{(256 - NUM_EVENTS){1'b0}}, event_vec_i} << 1;

  // Per-counter increment request before inhibit and write suppression.
  always_comb begin
    incReq    = '0;
    incReq[0] = 1'b1;
    incReq[2] = inst_commit_i;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      incReq[3 + i] = evPad[evt_q[i][7:0]];
    end
  end

  // Next-state for counters and control registers. A write to a counter half
  // takes precedence over, and cancels, that counter's increment this cycle.
  // The old inhibit value governs the current cycle's increments.
  always_comb begin
    cnt_d       = cnt_q;
    evt_d       = evt_q;
    inhibit_d   = inhibit_q;
    counteren_d = counteren_q;
`ifdef HPM_OVF_IRQ_EN
    ovfSet = '0;
    ovfClr = '0;
    ovfEn  = '0;
`endif
    wAcc = csr_wen_i && (priv_level_i >= csr_waddr_i[9:8]) &&
           (csr_waddr_i[11:10] != 2'b11);

    for (int n = 0; n <= TOP; n++) begin
      if (n != 1) begin
        if (wAcc && csr_waddr_i == 12'(32'hB00 + n)) begin
          cnt_d[n][31:0] = csr_wdata_i;
        end else if (wAcc && csr_waddr_i == 12'(32'hB80 + n)) begin
          cnt_d[n][63:32] = csr_wdata_i;
        end else if (incReq[n] && !inhibit_q[n]) begin
          cnt_d[n] = cnt_q[n] + 64'd1;
`ifdef HPM_OVF_IRQ_EN
          if (n >= 3 && (&cnt_q[n])) ovfSet[n] = 1'b1;
`endif
        end
      end
    end

    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (wAcc && csr_waddr_i == 12'(32'h323 + i)) evt_d[i] = csr_wdata_i & EVT_MASK;
    end
    if (wAcc && csr_waddr_i == 12'h320) inhibit_d   = csr_wdata_i & IMPL_MASK;
    if (wAcc && csr_waddr_i == 12'h306) counteren_d = csr_wdata_i & IMPL_MASK;

`ifdef HPM_OVF_IRQ_EN
    // New wraps win over a same-cycle clear so no overflow is lost.
    if (wAcc && csr_waddr_i == 12'h7C0) ovfClr = csr_wdata_i;
    ovf_d = (ovf_q & ~ovfClr) | ovfSet;
    for (int i = 0; i < NUM_COUNTERS; i++) ovfEn[3 + i] = evt_q[i][31];
    irq_d = |(ovf_d & ovfEn);
`endif
  end

  // Read decode. Shadows return the same halves as the machine counters but
  // are gated by mcounteren outside machine mode. Same-address writes are
  // forwarded only for addresses that decode legally.
  always_comb begin
    csr_rdata_o   = '0;
    csr_hit_o     = 1'b0;
    csr_illegal_o = 1'b0;
    for (int n = 0; n <= TOP; n++) begin
      if (n != 1) begin
        if (csr_raddr_i == 12'(32'hB00 + n)) begin
          csr_hit_o   = 1'b1;
          csr_rdata_o = cnt_q[n][31:0];
        end
        if (csr_raddr_i == 12'(32'hB80 + n)) begin
          csr_hit_o   = 1'b1;
          csr_rdata_o = cnt_q[n][63:32];
        end
        if (csr_raddr_i == 12'(32'hC00 + n) || csr_raddr_i == 12'(32'hC80 + n)) begin
          csr_hit_o = 1'b1;
          if (priv_level_i == 2'b11 || counteren_q[n]) begin
            csr_rdata_o = csr_raddr_i[7] ? cnt_q[n][63:32] : cnt_q[n][31:0];
          end else begin
            csr_illegal_o = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_raddr_i == 12'(32'h323 + i)) begin
        csr_hit_o   = 1'b1;
        csr_rdata_o = evt_q[i];
      end
    end
    if (csr_raddr_i == 12'h320) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = inhibit_q;
    end
    if (csr_raddr_i == 12'h306) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = counteren_q;
    end
`ifdef HPM_OVF_IRQ_EN
    if (csr_raddr_i == 12'h7C0) begin
      csr_hit_o   = 1'b1;
      csr_rdata_o = ovf_q;
    end
`endif
    if (csr_wen_i && csr_waddr_i == csr_raddr_i && csr_hit_o && !csr_illegal_o) begin
      csr_rdata_o = csr_wdata_i;
    end
  end

  // State registers; reset has priority over every write and increment.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n <= TOP; n++) cnt_q[n] <= '0;
      for (int i = 0; i < NUM_COUNTERS; i++) evt_q[i] <= '0;
      inhibit_q   <= '0;
      counteren_q <= '0;
`ifdef HPM_OVF_IRQ_EN
      ovf_q <= '0;
      irq_q <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      evt_q       <= evt_d;
      inhibit_q   <= inhibit_d;
      counteren_q <= counteren_d;
`ifdef HPM_OVF_IRQ_EN
      ovf_q <= ovf_d;
      irq_q <= irq_d;
`endif
    end
  end

`ifdef HPM_OVF_IRQ_EN
  assign ovf_irq_o = irq_q;
`else
  assign ovf_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_csr_hpm_counters.sv
// ----------------------------------------------------------------------------
// tb_csr_hpm_counters
//
// Directed bench for csr_hpm_counters with the default parameters
// (NUM_COUNTERS = 4, NUM_EVENTS = 8). Inputs change 1 ns after the rising
// edge and outputs are sampled before the next rising edge.
// ----------------------------------------------------------------------------
module tb_csr_hpm_counters;

  logic        clk;
  logic        rst;
  logic [1:0]  priv;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic        csr_illegal;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        inst_commit;
  logic [7:0]  event_vec;
  logic        ovf_irq;

  int checks = 0;
  int errors = 0;

  logic [31:0] d;
  logic        h;
  logic        il;

  csr_hpm_counters #(
    .DATA_WIDTH  (32),
    .NUM_COUNTERS(4),
    .NUM_EVENTS  (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .priv_level_i (priv),
    .csr_raddr_i  (csr_raddr),
    .csr_rdata_o  (csr_rdata),
    .csr_hit_o    (csr_hit),
    .csr_illegal_o(csr_illegal),
    .csr_wen_i    (csr_wen),
    .csr_waddr_i  (csr_waddr),
    .csr_wdata_i  (csr_wdata),
    .inst_commit_i(inst_commit),
    .event_vec_i  (event_vec),
    .ovf_irq_o    (ovf_irq)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational read: present the address and let it settle for 1 ns.
  task automatic readCsr(input logic [11:0] addr, output logic [31:0] data,
                         output logic hit, output logic ill);
    csr_raddr = addr;
    #1;
    data = csr_rdata;
    hit  = csr_hit;
    ill  = csr_illegal;
  endtask

  // One-cycle write strobe at the current privilege level.
  task automatic writeCsr(input logic [11:0] addr, input logic [31:0] data);
    csr_wen   = 1'b1;
    csr_waddr = addr;
    csr_wdata = data;
    @(posedge clk);
    #1;
    csr_wen = 1'b0;
  endtask

  // Hold event_vec for a number of rising edges, then clear it.
  task automatic pulseEvents(input logic [7:0] ev, input int cycles);
    event_vec = ev;
    repeat (cycles) @(posedge clk);
    #1;
    event_vec = '0;
  endtask

  // Reset followed by 10 idle cycles.
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    readCsr(12'hB00, d, h, il);
    checks++;
    if (d !== 32'd10 || h !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mcycle: got %h hit %b, expected 0000000a hit 1", d, h);
    end
    readCsr(12'hB80, d, h, il);
    checks++;
    if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_mcycleh: got %h expected 0", d); end
    readCsr(12'hB02, d, h, il);
    checks++;
    if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_minstret: got %h expected 0", d); end
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_hpm3: got %h expected 0", d); end
    readCsr(12'h323, d, h, il);
    checks++;
    if (d !== 32'd0 || h !== 1'b1) begin errors++; $display("[TB] FAIL reset_mhpmevent3: got %h hit %b expected 0 hit 1", d, h); end
    readCsr(12'h320, d, h, il);
    checks++;
    if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_inhibit: got %h expected 0", d); end
    readCsr(12'h306, d, h, il);
    checks++;
    if (d !== 32'd0) begin errors++; $display("[TB] FAIL reset_counteren: got %h expected 0", d); end
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", ovf_irq); end
  endtask

  // Event selection, inhibit and register masking.
  task automatic test_event_count();
    writeCsr(12'h323, 32'd2);
    pulseEvents(8'h02, 5);
    writeCsr(12'h320, 32'h8);
    pulseEvents(8'h02, 3);
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'd5) begin errors++; $display("[TB] FAIL event_count: got %h expected 5", d); end
    readCsr(12'h320, d, h, il);
    checks++;
    if (d !== 32'h8) begin errors++; $display("[TB] FAIL inhibit_read: got %h expected 8", d); end
    writeCsr(12'h320, 32'hFFFF_FFFF);
    readCsr(12'h320, d, h, il);
    checks++;
    if (d !== 32'h7D) begin errors++; $display("[TB] FAIL inhibit_mask: got %h expected 0000007d", d); end
    writeCsr(12'h320, 32'h0);
    writeCsr(12'h323, 32'hFFFF_FFFF);
    readCsr(12'h323, d, h, il);
    checks++;
    if (d !== 32'h8000_00FF) begin errors++; $display("[TB] FAIL event_mask: got %h expected 800000ff", d); end
    pulseEvents(8'hFF, 1);
    writeCsr(12'h323, 32'd2);
    pulseEvents(8'h01, 1);
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'd5) begin errors++; $display("[TB] FAIL event_nonselected: got %h expected 5", d); end
  endtask

  // Carry from low to high half, write/increment collision, parallel write.
  task automatic test_wrap_and_write();
    writeCsr(12'hB03, 32'hFFFF_FFFF);
    writeCsr(12'hB83, 32'h0);
    pulseEvents(8'h02, 1);
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL carry_low: got %h expected 0", d); end
    readCsr(12'hB83, d, h, il);
    checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL carry_high: got %h expected 1", d); end
    event_vec = 8'h02;
    writeCsr(12'hB03, 32'h1234);
    event_vec = 8'h00;
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'h1234) begin errors++; $display("[TB] FAIL write_beats_inc: got %h expected 00001234", d); end
    readCsr(12'hB83, d, h, il);
    checks++;
    if (d !== 32'h1) begin errors++; $display("[TB] FAIL write_keeps_high: got %h expected 1", d); end
    event_vec = 8'h02;
    writeCsr(12'hB02, 32'h55);
    event_vec = 8'h00;
    readCsr(12'hB02, d, h, il);
    checks++;
    if (d !== 32'h55) begin errors++; $display("[TB] FAIL parallel_write: got %h expected 55", d); end
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'h1235) begin errors++; $display("[TB] FAIL parallel_inc: got %h expected 00001235", d); end
  endtask

  // Same-address write forwarding and unmapped addresses.
  task automatic test_bypass();
    csr_raddr = 12'hB03;
    csr_wen   = 1'b1;
    csr_waddr = 12'hB03;
    csr_wdata = 32'hABCD;
    #1;
    checks++;
    if (csr_rdata !== 32'hABCD) begin errors++; $display("[TB] FAIL bypass: got %h expected 0000abcd", csr_rdata); end
    @(posedge clk);
    #1;
    csr_wen = 1'b0;
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'hABCD) begin errors++; $display("[TB] FAIL bypass_commit: got %h expected 0000abcd", d); end
    csr_raddr = 12'h341;
    csr_wen   = 1'b1;
    csr_waddr = 12'h341;
    csr_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (csr_hit !== 1'b0 || csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL unmapped: got hit %b rdata %h ill %b, expected hit 0 rdata 0 ill 0",
               csr_hit, csr_rdata, csr_illegal);
    end
    @(posedge clk);
    #1;
    csr_wen = 1'b0;
  endtask

  // User shadow gating and user-mode write rejection.
  task automatic test_user_shadow();
    writeCsr(12'h320, 32'h1);
    writeCsr(12'hB00, 32'h1000);
    writeCsr(12'hB80, 32'h0);
    priv = 2'b00;
    readCsr(12'hC00, d, h, il);
    checks++;
    if (d !== 32'h0 || il !== 1'b1) begin errors++; $display("[TB] FAIL shadow_blocked: got %h ill %b expected 0 ill 1", d, il); end
    priv = 2'b11;
    writeCsr(12'h306, 32'h1);
    priv = 2'b00;
    readCsr(12'hC00, d, h, il);
    checks++;
    if (d !== 32'h1000 || il !== 1'b0) begin errors++; $display("[TB] FAIL shadow_allowed: got %h ill %b expected 00001000 ill 0", d, il); end
    readCsr(12'hC80, d, h, il);
    checks++;
    if (d !== 32'h0 || il !== 1'b0) begin errors++; $display("[TB] FAIL shadow_high: got %h ill %b expected 0 ill 0", d, il); end
    readCsr(12'hC03, d, h, il);
    checks++;
    if (il !== 1'b1 || h !== 1'b1) begin errors++; $display("[TB] FAIL shadow_hpm3_blocked: got ill %b hit %b expected ill 1 hit 1", il, h); end
    writeCsr(12'hB00, 32'hDEAD);
    priv = 2'b11;
    readCsr(12'hB00, d, h, il);
    checks++;
    if (d !== 32'h1000) begin errors++; $display("[TB] FAIL user_write_dropped: got %h expected 00001000", d); end
    writeCsr(12'h320, 32'h0);
  endtask

  // Wrap of mhpmcounter3 from all-ones with the IRQ enable set.
  task automatic test_overflow();
    writeCsr(12'h323, 32'h8000_0001);
    writeCsr(12'hB03, 32'hFFFF_FFFF);
    writeCsr(12'hB83, 32'hFFFF_FFFF);
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_before_wrap: got %b expected 0", ovf_irq); end
    pulseEvents(8'h01, 1);
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL wrap_low: got %h expected 0", d); end
    readCsr(12'hB83, d, h, il);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL wrap_high: got %h expected 0", d); end
`ifdef HPM_OVF_IRQ_EN
    checks++;
    if (ovf_irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_after_wrap: got %b expected 1", ovf_irq); end
    readCsr(12'h7C0, d, h, il);
    checks++;
    if (d !== 32'h8 || h !== 1'b1) begin errors++; $display("[TB] FAIL ovf_status: got %h hit %b expected 8 hit 1", d, h); end
    writeCsr(12'h7C0, 32'h8);
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_cleared: got %b expected 0", ovf_irq); end
    readCsr(12'h7C0, d, h, il);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL ovf_status_cleared: got %h expected 0", d); end
`else
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_tied_low: got %b expected 0", ovf_irq); end
    writeCsr(12'h7C0, 32'hFFFF_FFFF);
    readCsr(12'h7C0, d, h, il);
    checks++;
    if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("[TB] FAIL ovf_unmapped: got %h hit %b expected 0 hit 0", d, h); end
`endif
  endtask

  // Reset arriving together with a write and an event.
  task automatic test_reset_priority();
    event_vec = 8'h01;
    rst       = 1'b1;
    csr_wen   = 1'b1;
    csr_waddr = 12'hB03;
    csr_wdata = 32'h77;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    csr_wen   = 1'b0;
    event_vec = 8'h00;
    readCsr(12'hB00, d, h, il);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL rst_mcycle: got %h expected 0", d); end
    readCsr(12'hB03, d, h, il);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL rst_beats_write: got %h expected 0", d); end
    readCsr(12'h323, d, h, il);
    checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL rst_event_sel: got %h expected 0", d); end
    checks++;
    if (ovf_irq !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq: got %b expected 0", ovf_irq); end
  endtask

  // Test sequence
  initial begin
    rst         = 1'b1;
    priv        = 2'b11;
    csr_raddr   = '0;
    csr_wen     = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    inst_commit = 1'b0;
    event_vec   = '0;
    test_reset();
    test_event_count();
    test_wrap_and_write();
    test_bypass();
    test_user_shadow();
    test_overflow();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
